// File: rtl/mips_cpu_regfile_pkg.sv
// mips_cpu_regfile_pkg: shared types (reg_addr_t, word_t, wb_entry_t), SEQ_W sizing and modular seq age compare for the write-port scheduler
package mips_cpu_regfile_pkg;
  localparam int SEQ_MAX_W = 8;
  typedef logic [4:0] reg_addr_t;
  typedef logic [31:0] word_t;
  typedef logic [SEQ_MAX_W-1:0] seq_t;
  typedef struct packed {
    reg_addr_t addr;
    word_t data;
    seq_t seq;
  } wb_entry_t;
  function automatic int SEQ_W(input int depth);
    return $clog2(2 * depth) + 1;
  endfunction
  function automatic logic seq_newer(input seq_t a, input seq_t b, input int sw);
    seq_t d;
    d = a - b;
    return ((d & ((seq_t'(1) << sw) - seq_t'(1))) != '0) && ((d & (seq_t'(1) << (sw - 1))) == '0);
  endfunction
endpackage

// File: rtl/mips_cpu_wb_fifo.sv
// mips_cpu_wb_fifo: DEPTH-entry wb_entry_t ring (clk, reset, push/din, pop, ready, head_valid/head, vld plus ents when MIPS_CPU_REGFILE_BYPASS_EN else ent_addr)
module mips_cpu_wb_fifo
  import mips_cpu_regfile_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  wb_entry_t        din,
  input  logic             pop,
  output logic             ready,
  output logic             head_valid,
  output wb_entry_t        head,
  output logic [DEPTH-1:0] vld,
`ifdef MIPS_CPU_REGFILE_BYPASS_EN
  output wb_entry_t        ents [DEPTH]
`else
  output reg_addr_t        ent_addr [DEPTH]
`endif
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [PW-1:0] rd, wr;
  logic [CW-1:0] cnt;
  wb_entry_t mem [DEPTH];
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  always_ff @(posedge clk)
    if (reset) begin
      rd <= '0;
      wr <= '0;
      cnt <= '0;
    end else begin
      if (push) begin
        mem[wr] <= din;
        wr <= nxt(wr);
      end
      if (pop) rd <= nxt(rd);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  assign ready = !reset && (cnt != CW'(DEPTH));
  assign head_valid = cnt != '0;
  assign head = mem[rd];
  always_comb
    for (int i = 0; i < DEPTH; i++)
      vld[i] = ((i >= int'(rd)) ? i - int'(rd) : i + DEPTH - int'(rd)) < int'(cnt);
`ifdef MIPS_CPU_REGFILE_BYPASS_EN
  assign ents = mem;
`else
  always_comb
    for (int i = 0; i < DEPTH; i++)
      ent_addr[i] = mem[i].addr;
`endif
endmodule

// File: rtl/mips_cpu_regfile_wrarb.sv
// mips_cpu_regfile_wrarb: merges ALU (req0*) and load (req1*) writebacks oldest-first onto write/wrAddr/wrData and resolves rdAddrA/B hazards (fwdData*, haz*); MIPS_CPU_REGFILE_BYPASS_EN forwards queued data instead of stalling
module mips_cpu_regfile_wrarb
  import mips_cpu_regfile_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0Valid,
  output logic        req0Ready,
  input  logic [4:0]  req0Addr,
  input  logic [31:0] req0Data,
  input  logic        req1Valid,
  output logic        req1Ready,
  input  logic [4:0]  req1Addr,
  input  logic [31:0] req1Data,
  output logic        write,
  output logic [4:0]  wrAddr,
  output logic [31:0] wrData,
  input  logic [4:0]  rdAddrA,
  input  logic [4:0]  rdAddrB,
  input  logic [31:0] rdDataA,
  input  logic [31:0] rdDataB,
  output logic [31:0] fwdDataA,
  output logic [31:0] fwdDataB,
  output logic        hazA,
  output logic        hazB
);
  localparam int SW = SEQ_W(DEPTH);
  localparam int N = 2 * DEPTH;
  localparam seq_t MASK = seq_t'((1 << SW) - 1);
  seq_t seq;
  logic acc0, acc1, pop0, pop1, hv0, hv1, sel1;
  wb_entry_t h0, h1;
  logic [DEPTH-1:0] v0, v1;
  logic [N-1:0] all_v;
  reg_addr_t ra [2];
  word_t rdd [2];
  word_t fwd [2];
  logic [1:0] hit;
  assign acc0 = req0Valid && req0Ready && (req0Addr != 5'd0);
  assign acc1 = req1Valid && req1Ready && (req1Addr != 5'd0);
  always_ff @(posedge clk)
    if (reset) seq <= '0;
    else seq <= (seq + seq_t'(acc0) + seq_t'(acc1)) & MASK;
`ifdef MIPS_CPU_REGFILE_BYPASS_EN
  wb_entry_t e0 [DEPTH], e1 [DEPTH], all_e [N], best [2];
`else
  reg_addr_t e0 [DEPTH], e1 [DEPTH], all_a [N];
`endif
  mips_cpu_wb_fifo #(.DEPTH(DEPTH)) u_q0 (
    .clk(clk), .reset(reset), .push(acc0),
    .din('{addr: req0Addr, data: req0Data, seq: seq}),
    .pop(pop0), .ready(req0Ready), .head_valid(hv0), .head(h0), .vld(v0),
`ifdef MIPS_CPU_REGFILE_BYPASS_EN
    .ents(e0)
`else
    .ent_addr(e0)
`endif
  );
  mips_cpu_wb_fifo #(.DEPTH(DEPTH)) u_q1 (
    .clk(clk), .reset(reset), .push(acc1),
    .din('{addr: req1Addr, data: req1Data, seq: acc0 ? (seq + seq_t'(1)) & MASK : seq}),
    .pop(pop1), .ready(req1Ready), .head_valid(hv1), .head(h1), .vld(v1),
`ifdef MIPS_CPU_REGFILE_BYPASS_EN
    .ents(e1)
`else
    .ent_addr(e1)
`endif
  );
  assign sel1 = hv1 && (!hv0 || seq_newer(h0.seq, h1.seq, SW));
  assign write = !reset && (hv0 || hv1);
  assign pop0 = write && !sel1;
  assign pop1 = write && sel1;
  assign wrAddr = write ? (sel1 ? h1.addr : h0.addr) : '0;
  assign wrData = write ? (sel1 ? h1.data : h0.data) : '0;
  assign all_v = {v1, v0};
  assign ra[0] = rdAddrA;
  assign ra[1] = rdAddrB;
  assign rdd[0] = rdDataA;
  assign rdd[1] = rdDataB;
`ifdef MIPS_CPU_REGFILE_BYPASS_EN
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      all_e[i] = e0[i];
      all_e[i+DEPTH] = e1[i];
    end
    for (int p = 0; p < 2; p++) begin
      hit[p] = 1'b0;
      best[p] = '0;
      for (int j = 0; j < N; j++)
        if (all_v[j] && all_e[j].addr == ra[p] && (!hit[p] || seq_newer(all_e[j].seq, best[p].seq, SW))) begin
          hit[p] = 1'b1;
          best[p] = all_e[j];
        end
      fwd[p] = (hit[p] && ra[p] != 5'd0 && !reset) ? best[p].data : rdd[p];
    end
  end
  assign hazA = 1'b0;
  assign hazB = 1'b0;
`else
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      all_a[i] = e0[i];
      all_a[i+DEPTH] = e1[i];
    end
    for (int p = 0; p < 2; p++) begin
      hit[p] = 1'b0;
      for (int j = 0; j < N; j++)
        hit[p] = hit[p] | (all_v[j] && all_a[j] == ra[p]);
      fwd[p] = rdd[p];
    end
  end
  assign hazA = hit[0] && rdAddrA != 5'd0 && !reset;
  assign hazB = hit[1] && rdAddrB != 5'd0 && !reset;
`endif
  assign fwdDataA = fwd[0];
  assign fwdDataB = fwd[1];
endmodule

// File: tb/tb_mips_cpu_regfile_wrarb.sv
// tb_mips_cpu_regfile_wrarb: random and directed writeback traffic scored against a queue model of commit order, readiness and read hazards
module tb_mips_cpu_regfile_wrarb;
  localparam int DEPTH = 2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req0Valid = 1'b0, req1Valid = 1'b0;
  logic req0Ready, req1Ready;
  logic [4:0] req0Addr = '0, req1Addr = '0;
  logic [31:0] req0Data = '0, req1Data = '0;
  logic write;
  logic [4:0] wrAddr;
  logic [31:0] wrData;
  logic [4:0] rdAddrA = '0, rdAddrB = '0;
  logic [31:0] rdDataA, rdDataB, fwdDataA, fwdDataB;
  logic hazA, hazB;
  logic [31:0] rf [32];
  typedef struct {
    int port;
    logic [4:0] a;
    logic [31:0] d;
  } ent_t;
  ent_t q[$];
  ent_t pend[$];
  int cnt[2] = '{0, 0};
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  mips_cpu_regfile_wrarb #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req0Valid(req0Valid), .req0Ready(req0Ready), .req0Addr(req0Addr), .req0Data(req0Data),
    .req1Valid(req1Valid), .req1Ready(req1Ready), .req1Addr(req1Addr), .req1Data(req1Data),
    .write(write), .wrAddr(wrAddr), .wrData(wrData),
    .rdAddrA(rdAddrA), .rdAddrB(rdAddrB), .rdDataA(rdDataA), .rdDataB(rdDataB),
    .fwdDataA(fwdDataA), .fwdDataB(fwdDataB), .hazA(hazA), .hazB(hazB)
  );
  assign rdDataA = rf[rdAddrA];
  assign rdDataB = rf[rdAddrB];
  always @(posedge clk) if (write && wrAddr != 5'd0) rf[wrAddr] <= wrData;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h at %0t", n, act, exp, $time);
    end
  endtask
  task automatic exp_read(input string n, input logic [4:0] a, input logic [31:0] rd,
                          input logic [31:0] fwd, input logic h);
    logic m;
`ifdef MIPS_CPU_REGFILE_BYPASS_EN
    logic [31:0] y;
    y = '0;
`endif
    m = 1'b0;
    if (a != 5'd0)
      foreach (q[i])
        if (q[i].a == a) begin
          m = 1'b1;
`ifdef MIPS_CPU_REGFILE_BYPASS_EN
          y = q[i].d;
`endif
        end
`ifdef MIPS_CPU_REGFILE_BYPASS_EN
    chk({n, "_fwd"}, fwd, m ? y : rd);
    chk({n, "_haz"}, h, 0);
`else
    chk({n, "_fwd"}, fwd, rd);
    chk({n, "_haz"}, h, m);
`endif
  endtask
  always @(negedge clk) begin
    exp_read("rdA", rdAddrA, rdDataA, fwdDataA, hazA);
    exp_read("rdB", rdAddrB, rdDataB, fwdDataB, hazB);
    if (q.size() != 0) begin
      chk("commit", {write, wrAddr, wrData}, {1'b1, q[0].a, q[0].d});
      cnt[q[0].port]--;
      void'(q.pop_front());
    end else chk("idle", {write, wrAddr, wrData}, 64'd0);
  end
  task automatic cyc(input logic r, input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                     input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                     input logic [4:0] ra, input logic [4:0] rb);
    logic rdy0, rdy1;
    @(posedge clk);
    #1;
    foreach (pend[i]) q.push_back(pend[i]);
    pend.delete();
    reset = r;
    if (r) begin
      q.delete();
      cnt[0] = 0;
      cnt[1] = 0;
    end
    #1;
    rdy0 = !r && cnt[0] < DEPTH;
    rdy1 = !r && cnt[1] < DEPTH;
    chk("ready0", req0Ready, rdy0);
    chk("ready1", req1Ready, rdy1);
    req0Valid = v0; req0Addr = a0; req0Data = d0;
    req1Valid = v1; req1Addr = a1; req1Data = d1;
    rdAddrA = ra; rdAddrB = rb;
    if (rdy0 && v0 && a0 != 5'd0) begin
      pend.push_back('{0, a0, d0});
      cnt[0]++;
    end
    if (rdy1 && v1 && a1 != 5'd0) begin
      pend.push_back('{1, a1, d1});
      cnt[1]++;
    end
  endtask
  task automatic idle(input int n, input logic [4:0] ra);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, ra, 5'd5);
  endtask
  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    cyc(1, 0, 0, 0, 0, 0, 0, 5, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 5, 0);
    idle(2, 5);
    cyc(0, 1, 10, 45, 0, 0, 0, 10, 0);
    idle(3, 10);
    chk("rf10", rf[10], 45);
    cyc(0, 1, 12, 35, 1, 12, 9, 12, 12);
    idle(4, 12);
    chk("rf12", rf[12], 9);
    cyc(0, 0, 0, 0, 1, 0, 5, 0, 0);
    idle(2, 0);
    cyc(0, 0, 0, 0, 1, 3, 1, 0, 3);
    cyc(0, 1, 20, 100, 1, 4, 2, 20, 4);
    cyc(0, 1, 21, 101, 1, 6, 3, 21, 6);
    cyc(0, 1, 22, 102, 0, 0, 0, 22, 3);
    cyc(0, 1, 22, 102, 0, 0, 0, 22, 3);
    cyc(0, 1, 22, 102, 0, 0, 0, 22, 3);
    idle(8, 22);
    cyc(0, 1, 3, 11, 1, 7, 99, 7, 3);
    idle(4, 7);
    chk("rf7", rf[7], 99);
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 199) == 0,
          $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
          $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    idle(10, 0);
    chk("drain", q.size() + pend.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
